// File: rtl/mem_preloader.sv
// Boot-time ICCM/DCCM preloader: parses a header/data word stream
// and emits one memory write strobe per accepted data word.
package top_pkg;
   parameter int TL_DW = 32;
endpackage

module mem_preloader #(
   parameter int DW = top_pkg::TL_DW,
   parameter int AW = 11
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          in_valid_i,
   input  logic [DW-1:0] in_data_i,
   output logic          in_ready_o,
   output logic          iccm_we_o,
   output logic          dccm_we_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic [DW-1:0] mem_wmask_o,
   output logic [AW-1:0] mem_waddr_o,
   output logic          mem_finish_o,
   output logic          err_o
);

   typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_t;

   state_t        state;
   state_t        nxt;
   logic          rdy;
   logic          take;
   logic          tgt;
   logic [11:0]   rem;
   logic [AW-1:0] ptr;
   logic          iccm_we;
   logic          dccm_we;
   logic [DW-1:0] wdata;
   logic [AW-1:0] waddr;
   logic          magic_ok;
   logic [11:0]   cnt;
   logic [AW-1:0] start;

   assign take     = in_valid_i & rdy;
   assign magic_ok = in_data_i[31:24] == 8'hA5;
   assign cnt      = in_data_i[11:0];
   assign start    = in_data_i[12 +: AW];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= HDR;
      else         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         HDR: begin
            if (take) begin
               if (!magic_ok)      nxt = ERR;
               else if (cnt == '0) nxt = DONE;
               else                nxt = DATA;
            end
         end
         DATA: begin
            if (take && rem == 12'd1) nxt = HDR;
         end
         DONE:    nxt = DONE;
         ERR:     nxt = ERR;
         default: nxt = HDR;
      endcase
   end

   // Ready is registered so it stays low until the first edge after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy     <= 1'b0;
         tgt     <= 1'b0;
         rem     <= '0;
         ptr     <= '0;
         iccm_we <= 1'b0;
         dccm_we <= 1'b0;
         wdata   <= '0;
         waddr   <= '0;
      end else begin
         rdy     <= (nxt == HDR) || (nxt == DATA);
         iccm_we <= 1'b0;
         dccm_we <= 1'b0;
         if (take && state == HDR && magic_ok && cnt != '0) begin
            tgt <= in_data_i[23];
            ptr <= start;
            rem <= cnt;
         end
         if (take && state == DATA) begin
            iccm_we <= ~tgt;
            dccm_we <= tgt;
            wdata   <= in_data_i;
            waddr   <= ptr;
            ptr     <= ptr + AW'(1);
            rem     <= rem - 12'd1;
         end
      end
   end

   assign in_ready_o   = rdy;
   assign iccm_we_o    = iccm_we;
   assign dccm_we_o    = dccm_we;
   assign mem_wdata_o  = wdata;
   assign mem_wmask_o  = '1;
   assign mem_waddr_o  = waddr;
   assign mem_finish_o = state == DONE;
   assign err_o        = state == ERR;

endmodule
